// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory controller.
// Holds the access FSM encoding and counter sizing.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DMEM_DEPTH = 64;
    localparam int DMEM_WAIT  = 2;
    localparam int CNT_W      = 4;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data storage: synchronous write, registered read.
// Only the read register is reset; the array keeps its contents.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = addr_bits(DMEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: checks requests, stalls the
// pipeline for a fixed latency and performs one access per request.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_CYCLES = DMEM_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemErr
);

    localparam int AW = addr_bits(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic             wr_q;

    logic req_any;
    logic one_dir;
    logic aligned;
    logic in_range;
    logic req_ok;
    logic is_idle;
    logic is_busy;
    logic finish;
    logic ram_we;
    logic ram_re;

    assign req_any  = MemRead | MemWrite;
    assign one_dir  = MemRead ^ MemWrite;
    assign aligned  = (ALUResult[1:0] == 2'b00);
    assign in_range = (ALUResult[31:2] < 30'(DEPTH));
    assign req_ok   = one_dir & aligned & in_range;

    assign is_idle = (state_q == IDLE);
    assign is_busy = (state_q == BUSY);
    assign finish  = is_busy & (cnt_q == CNT_LAST);

    // Reset gating keeps both outputs low while reset is held.
    assign Stall  = ~reset & (is_busy | (is_idle & req_ok));
    assign MemErr = ~reset & is_idle & req_any & ~req_ok;

    assign ram_we = finish & wr_q;
    assign ram_re = finish & ~wr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_ok) begin
                        addr_q  <= ALUResult[AW+1:2];
                        wdata_q <= WriteData;
                        wr_q    <= MemWrite;
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ReadData)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed accesses, error cases,
// reset abort and a WAIT_CYCLES=1 back-to-back instance.
module tb_dmem_ctrl;

    localparam int WAITN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MemErr;

    logic        r1 = 1'b0;
    logic        w1 = 1'b0;
    logic [31:0] a1 = '0;
    logic [31:0] d1 = '0;
    logic [31:0] rdata1;
    logic        stall1;
    logic        err1;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DEPTH       (64),
        .WAIT_CYCLES (WAITN)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemErr    (MemErr)
    );

    dmem_ctrl #(
        .DEPTH       (64),
        .WAIT_CYCLES (1)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (r1),
        .MemWrite  (w1),
        .ALUResult (a1),
        .WriteData (d1),
        .ReadData  (rdata1),
        .Stall     (stall1),
        .MemErr    (err1)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] rd_model = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic acc(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit scramble);
        exp_t e;
        e.is_err = 1'b0;
        e.rd     = exp_rd;
        sb.push_back(e);
        MemRead   = rd;
        MemWrite  = wr;
        ALUResult = a;
        WriteData = d;
        @(posedge clk);
        #1;
        if (scramble) begin
            ALUResult = a + 32'd4;
            WriteData = ~d;
            MemRead   = ~rd;
            MemWrite  = ~wr;
        end else begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
        repeat (WAITN) @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic bad(input logic rd, input logic wr,
                       input logic [31:0] a);
        exp_t e;
        e.is_err = 1'b1;
        e.rd     = rd_model;
        sb.push_back(e);
        MemRead   = rd;
        MemWrite  = wr;
        ALUResult = a;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin : monitor
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk or posedge reset);
            if (reset) begin
                run = 0;
            end else begin
                if (MemErr) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_err: got MemErr=1 expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("err_kind", 32'(e.is_err), 32'd1);
                        chk("err_stall", 32'(Stall), 32'd0);
                        chk("err_rdata", ReadData, e.rd);
                    end
                end
                if (Stall) begin
                    run++;
                end else if (run > 0) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_done: got stall run %0d expected none", run);
                    end else begin
                        e = sb.pop_front();
                        chk("done_kind", 32'(e.is_err), 32'd0);
                        chk("stall_len", 32'(run), 32'(WAITN + 1));
                        chk("done_rdata", ReadData, e.rd);
                    end
                    run = 0;
                end
            end
        end
    end

    initial begin : stim
        logic [5:0] pat;
        #1 reset = 1'b1;
        #2;
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_err", 32'(MemErr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd_model, 1'b0);
        rd_model = 32'hDEADBEEF;
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd_model, 1'b0);
        chk("rdata_hold", ReadData, 32'hDEADBEEF);

        bad(1'b1, 1'b0, 32'h12);
        bad(1'b1, 1'b0, 32'h100);
        bad(1'b1, 1'b1, 32'h10);
        chk("rdata_after_err", ReadData, 32'hDEADBEEF);

        acc(1'b0, 1'b1, 32'hFC, 32'h0BADCAFE, rd_model, 1'b0);
        rd_model = 32'h0BADCAFE;
        acc(1'b1, 1'b0, 32'hFC, 32'h0, rd_model, 1'b0);

        acc(1'b0, 1'b1, 32'h8, 32'h11111111, rd_model, 1'b0);
        rd_model = 32'h11111111;
        acc(1'b1, 1'b0, 32'h8, 32'h0, rd_model, 1'b0);

        MemWrite  = 1'b1;
        ALUResult = 32'h8;
        WriteData = 32'h55;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_rdata", ReadData, 32'd0);
        chk("abort_stall", 32'(Stall), 32'd0);
        chk("abort_err", 32'(MemErr), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        rd_model = 32'd0;
        @(posedge clk);
        #1;

        rd_model = 32'h11111111;
        acc(1'b1, 1'b0, 32'h8, 32'h0, rd_model, 1'b0);
        rd_model = 32'hDEADBEEF;
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd_model, 1'b0);

        acc(1'b0, 1'b1, 32'h24, 32'hA5A5A5A5, rd_model, 1'b0);
        acc(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, rd_model, 1'b1);
        rd_model = 32'hA5A5A5A5;
        acc(1'b1, 1'b0, 32'h24, 32'h0, rd_model, 1'b0);
        rd_model = 32'hCAFEF00D;
        acc(1'b1, 1'b0, 32'h20, 32'h0, rd_model, 1'b0);

        pat = 6'b011011;
        w1 = 1'b1;
        a1 = 32'h4;
        d1 = 32'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_stall%0d", i), 32'(stall1), 32'(pat[i]));
        end
        w1 = 1'b0;
        @(posedge clk);
        #1;
        r1 = 1'b1;
        @(posedge clk);
        #1;
        r1 = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_rdata", rdata1, 32'h77);
        chk("w1_done_stall", 32'(stall1), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit data words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning access latency in BUSY cycles; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemRead  input  1  load request from datapath/decoder.
REQ-006 SHALL have port MemWrite  input  1  store request from datapath/decoder.
REQ-007 SHALL have port ALUResult  input  32  byte address of access.
REQ-008 SHALL have port WriteData  input  32  store data.
REQ-009 SHALL have port ReadData  output  32  load data returned to the datapath result mux.
REQ-010 SHALL have port Stall  output  1  freeze PC/register writes while high.
REQ-011 SHALL have port MemErr  output  1  one-cycle error pulse for an illegal request.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL treat a request as valid when exactly one of MemRead/MemWrite is high, ALUResult[1:0]==0, and ALUResult[31:2] < DEPTH.
REQ-014 IDLE + valid request: Stall=1 combinationally; latch address, data, and direction; load counter with WAIT_CYCLES; next state BUSY.
REQ-015 IDLE + no request: Stall=0, remain IDLE.
REQ-016 BUSY: Stall=1; decrement counter each cycle; on the edge where counter==1, go to DONE.
REQ-017 SHALL perform the latched write, or register the read word into ReadData, on the BUSY->DONE edge only.
REQ-018 DONE: Stall=0, ReadData valid; next state IDLE unconditionally.
REQ-019 Total stall for a valid access SHALL be exactly WAIT_CYCLES+1 cycles, followed by one DONE cycle.
REQ-020 Input changes during BUSY SHALL be ignored; only latched values are used.
REQ-021 MemRead and MemWrite both high, a misaligned address, or an out-of-range address in IDLE SHALL produce MemErr=1 for that cycle, with no access, Stall=0, and state remaining IDLE.
REQ-022 ReadData SHALL hold its last loaded value until the next completed read; writes SHALL NOT alter ReadData.
REQ-023 MemErr SHALL be 0 in BUSY and DONE.
REQ-024 Word index SHALL be ALUResult[31:2], truncated to clog2(DEPTH) bits after the range check.

Reset
REQ-025 Reset SHALL force state IDLE, counter 0, ReadData 0, Stall 0, and MemErr 0 immediately, regardless of clock.
REQ-026 Reset during BUSY SHALL abort the access; a pending write SHALL NOT reach memory.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-028 Shared package dmem_pkg SHALL hold the state enum (IDLE/BUSY/DONE), default DEPTH, default WAIT_CYCLES, and the counter width (4).
REQ-029 Storage SHALL be one sub-module, dmem_ram: synchronous write, registered read, 32-bit word array.
REQ-030 The FSM, counter, and request checking SHALL reside in dmem_ctrl.

Verification
REQ-031 Write 0xDEADBEEF to 0x10 (WAIT=2) -> Stall high 3 cycles, DONE cycle Stall=0; memory word 4 = 0xDEADBEEF.
REQ-032 Read 0x10 after REQ-031 -> Stall high 3 cycles; ReadData=0xDEADBEEF in DONE cycle and held after it.
REQ-033 Read 0x12 (misaligned), read 0x100 (DEPTH=64), and MemRead=MemWrite=1 -> MemErr single pulse each, Stall=0, ReadData unchanged.
REQ-034 Write 0x55 to 0x8; assert reset in 2nd BUSY cycle -> outputs zeroed asynchronously; later read 0x8 returns the prior value, not 0x55.
REQ-035 Change ALUResult/WriteData during BUSY -> access uses the originally latched values.
REQ-036 Back-to-back requests (WAIT=1) -> IDLE,BUSY,DONE,IDLE,BUSY,DONE; Stall pattern 1,1,0,1,1,0.
